// File: rtl/sdram_test_pkg.sv
// Shared definitions for the SDRAM pattern tester: FSM state codes, pattern
// mode codes and the checkerboard word helper.
package sdram_test_pkg;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_WAIT_INIT = 4'd1;
  localparam logic [3:0] ST_WR_REQ    = 4'd2;
  localparam logic [3:0] ST_WR_STEP   = 4'd3;
  localparam logic [3:0] ST_RD_REQ    = 4'd4;
  localparam logic [3:0] ST_RD_WAIT   = 4'd5;
  localparam logic [3:0] ST_RD_CHK    = 4'd6;
  localparam logic [3:0] ST_DONE      = 4'd7;
  localparam logic [3:0] ST_FAIL      = 4'd8;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_ADDR    = 2'd0;
  localparam mode_t MODE_LFSR    = 2'd1;
  localparam mode_t MODE_CHECKER = 2'd2;
  localparam mode_t MODE_WALK    = 2'd3;

  localparam logic [15:0] DEFAULT_LFSR_POLY = 16'h100B;

  // Odd addresses get 0xAA.., even addresses 0x55..; callers truncate to width.
  function automatic logic [63:0] checker_word(input logic odd);
    return odd ? {32{2'b10}} : {32{2'b01}};
  endfunction

endpackage

// File: rtl/sdram_pattern_tester_if.sv
// Request/grant bus between the pattern tester (master) and my_sdram_ctrl (slave).
// write_req/read_req stay high with address/data stable until the matching
// grant rises; read data is taken on the rising edge of read_valid.
interface sdram_pattern_tester_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              clken;
  logic              busy;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] r_addr;
  logic              write_req;
  logic              write_gnt;
  logic              read_req;
  logic              read_gnt;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              read_valid;

  modport master (
    output clken, w_addr, r_addr, write_req, read_req, din,
    input  busy, write_gnt, read_gnt, dout, read_valid
  );

  modport slave (
    input  clken, w_addr, r_addr, write_req, read_req, din,
    output busy, write_gnt, read_gnt, dout, read_valid
  );
endinterface

// File: rtl/sdram_test_pattern.sv
// Pattern generator: maps (mode, address, pass parity) to a data word and owns
// the Galois LFSR that supplies the pseudo-random mode.
module sdram_test_pattern
  import sdram_test_pkg::*;
#(
  parameter int                ADDR_W    = 20,
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] LFSR_POLY = DATA_W'(DEFAULT_LFSR_POLY),
  parameter logic [DATA_W-1:0] LFSR_SEED = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  mode_t             i_mode,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_inv,
  input  logic              i_lfsr_load,
  input  logic              i_lfsr_step,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] r_lfsr;
  logic [DATA_W-1:0] w_raw;
  int unsigned       w_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_lfsr_load) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_lfsr_step) begin
      r_lfsr <= {r_lfsr[DATA_W-2:0], 1'b0} ^ (r_lfsr[DATA_W-1] ? LFSR_POLY : '0);
    end
  end

  always_comb begin
    w_a = 32'(i_addr);
    case (i_mode)
      MODE_ADDR:    w_raw = DATA_W'(i_addr);
      MODE_LFSR:    w_raw = r_lfsr;
      MODE_CHECKER: w_raw = DATA_W'(checker_word(i_addr[0]));
      default:      w_raw = DATA_W'(1) << (w_a % DATA_W);
    endcase
  end

  // Odd passes write and expect the complement of the base pattern.
  assign o_data = w_raw ^ {DATA_W{i_inv}};

endmodule

// File: rtl/sdram_pattern_tester.sv
// Self-checking SDRAM test engine: fills the address space with a pattern,
// reads it back, counts errors and captures the first failure.
module sdram_pattern_tester
  import sdram_test_pkg::*;
#(
  parameter int                ADDR_W     = 20,
  parameter int                DATA_W     = 16,
  parameter logic [DATA_W-1:0] LFSR_POLY  = DATA_W'(DEFAULT_LFSR_POLY),
  parameter logic [DATA_W-1:0] LFSR_SEED  = '1,
  parameter int                ERR_W      = 16,
  parameter int                RD_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  mode_t                   mode,
  input  logic                    loop,
  input  logic                    stop_on_err,
  sdram_pattern_tester_if.master  ctrl,
  output logic                    running,
  output logic                    done,
  output logic                    fail,
  output logic                    timeout,
  output logic [ERR_W-1:0]        err_count,
  output logic [ERR_W-1:0]        pass_count,
  output logic [ADDR_W-1:0]       fail_addr,
  output logic [DATA_W-1:0]       fail_exp,
  output logic [DATA_W-1:0]       fail_got,
  output logic [3:0]              dbg_state
);

  localparam int                TMR_W     = $clog2(RD_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [3:0]        r_state;
  mode_t             r_mode;
  logic              r_loop, r_soe, r_clken, r_timeout, r_rd_to;
  logic              r_busy, r_wgnt, r_rgnt, r_rvalid;
  logic [ADDR_W-1:0] r_addr, r_fail_addr;
  logic [DATA_W-1:0] r_got, r_fail_exp, r_fail_got;
  logic [ERR_W-1:0]  r_err, r_pass;
  logic [TMR_W-1:0]  r_timer;

  logic [DATA_W-1:0] w_exp;
  logic              w_busy_fall, w_wgnt_rise, w_rgnt_rise, w_rvalid_rise;
  logic              w_last, w_mismatch, w_stop, w_lfsr_load, w_lfsr_step;

  assign w_busy_fall   = r_busy && !ctrl.busy;
  assign w_wgnt_rise   = ctrl.write_gnt && !r_wgnt;
  assign w_rgnt_rise   = ctrl.read_gnt && !r_rgnt;
  assign w_rvalid_rise = ctrl.read_valid && !r_rvalid;
  assign w_last        = (r_addr == LAST_ADDR);
  assign w_mismatch    = r_rd_to || (r_got != w_exp);
  assign w_stop        = w_mismatch && r_soe;

  // Every phase (write sweep, read sweep, next loop pass) restarts from the seed.
  assign w_lfsr_load = ((r_state == ST_WAIT_INIT) && w_busy_fall) ||
                       ((r_state == ST_WR_STEP) && w_last) ||
                       ((r_state == ST_RD_CHK) && !w_stop && w_last);
  assign w_lfsr_step = ((r_state == ST_WR_STEP) && !w_last) ||
                       ((r_state == ST_RD_CHK) && !w_stop && !w_last);

  sdram_test_pattern #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .LFSR_POLY (LFSR_POLY),
    .LFSR_SEED (LFSR_SEED)
  ) u_pattern (
    .clk         (clk),
    .rst         (reset),
    .i_mode      (r_mode),
    .i_addr      (r_addr),
    .i_inv       (r_pass[0]),
    .i_lfsr_load (w_lfsr_load),
    .i_lfsr_step (w_lfsr_step),
    .o_data      (w_exp)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_ADDR;
      r_loop      <= 1'b0;
      r_soe       <= 1'b0;
      r_clken     <= 1'b0;
      r_timeout   <= 1'b0;
      r_rd_to     <= 1'b0;
      r_busy      <= 1'b0;
      r_wgnt      <= 1'b0;
      r_rgnt      <= 1'b0;
      r_rvalid    <= 1'b0;
      r_addr      <= '0;
      r_fail_addr <= '0;
      r_got       <= '0;
      r_fail_exp  <= '0;
      r_fail_got  <= '0;
      r_err       <= '0;
      r_pass      <= '0;
      r_timer     <= '0;
    end else begin
      r_busy   <= ctrl.busy;
      r_wgnt   <= ctrl.write_gnt;
      r_rgnt   <= ctrl.read_gnt;
      r_rvalid <= ctrl.read_valid;
      case (r_state)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start) begin
            r_mode      <= mode;
            r_loop      <= loop;
            r_soe       <= stop_on_err;
            r_clken     <= 1'b1;
            r_err       <= '0;
            r_pass      <= '0;
            r_fail_addr <= '0;
            r_fail_exp  <= '0;
            r_fail_got  <= '0;
            r_got       <= '0;
            r_timeout   <= 1'b0;
            r_rd_to     <= 1'b0;
            r_state     <= ST_WAIT_INIT;
          end
        end
        ST_WAIT_INIT: begin
          if (w_busy_fall) begin
            r_addr  <= '0;
            r_state <= ST_WR_REQ;
          end
        end
        ST_WR_REQ: begin
          if (w_wgnt_rise) r_state <= ST_WR_STEP;
        end
        ST_WR_STEP: begin
          r_addr  <= w_last ? '0 : r_addr + 1'b1;
          r_state <= w_last ? ST_RD_REQ : ST_WR_REQ;
        end
        ST_RD_REQ: begin
          if (w_rgnt_rise) begin
            r_timer <= '0;
            r_rd_to <= 1'b0;
            r_state <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (w_rvalid_rise) begin
            r_got   <= ctrl.dout;
            r_state <= ST_RD_CHK;
          end else if (r_timer == TMR_W'(RD_TIMEOUT - 1)) begin
            r_timeout <= 1'b1;
            r_rd_to   <= 1'b1;
            r_got     <= '0;
            r_state   <= ST_RD_CHK;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_RD_CHK: begin
          if (w_mismatch) begin
            if (r_err != '1) r_err <= r_err + 1'b1;
            if (r_err == '0) begin
              r_fail_addr <= r_addr;
              r_fail_exp  <= w_exp;
              r_fail_got  <= r_got;
            end
          end
          if (w_stop) begin
            r_state <= ST_FAIL;
          end else if (w_last) begin
            if (r_pass != '1) r_pass <= r_pass + 1'b1;
            r_addr  <= '0;
            r_state <= r_loop ? ST_WR_REQ : ST_DONE;
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_state <= ST_RD_REQ;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ctrl.clken     = r_clken;
  assign ctrl.w_addr    = r_addr;
  assign ctrl.r_addr    = r_addr;
  assign ctrl.din       = w_exp;
  assign ctrl.write_req = (r_state == ST_WR_REQ);
  assign ctrl.read_req  = (r_state == ST_RD_REQ);

  assign running    = !((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_FAIL));
  assign done       = (r_state == ST_DONE);
  assign fail       = (r_state == ST_FAIL) || ((r_state == ST_DONE) && (r_err != '0));
  assign timeout    = r_timeout;
  assign err_count  = r_err;
  assign pass_count = r_pass;
  assign fail_addr  = r_fail_addr;
  assign fail_exp   = r_fail_exp;
  assign fail_got   = r_fail_got;
  assign dbg_state  = r_state;

endmodule

// File: doc/sdram_pattern_tester.md
# sdram_pattern_tester

Parametrised self-checking SDRAM test engine that drives the write/read request ports of `my_sdram_ctrl`. It fills the full address space with a selectable data pattern and reads every location back. Each read is compared against a regenerated expected value; the engine counts errors and captures the first failure. It replaces ad-hoc test sequencers in board tops and runs alongside display/LED logic in the same `clk` domain.

## Interface
- `ADDR_W`, 20, word-address width; the test covers `0 .. 2**ADDR_W-1`.
- `DATA_W`, 16, data width, ≥ 2.
- `LFSR_POLY`, 16'h100B, Galois feedback mask, DATA_W bits.
- `LFSR_SEED`, all ones, LFSR value reloaded at the start of every phase; must be non-zero.
- `ERR_W`, 16, width of the error and pass counters.
- `RD_TIMEOUT`, 1024, maximum cycles from `read_gnt` rise to `read_valid` rise.

Ports:
- `clk` in 1, system clock.
- `reset` in 1, asynchronous, active-high.
- `start` in 1, one-cycle pulse that starts a test.
- `mode` in 2, sampled at start: 0 address, 1 LFSR, 2 checkerboard, 3 walking-one.
- `loop` in 1, sampled at start: repeat passes indefinitely.
- `stop_on_err` in 1, sampled at start: halt on the first error.
- `clken` out 1, controller enable.
- `busy` in 1, controller busy during init.
- `w_addr`, `r_addr` out ADDR_W, controller addresses.
- `write_req` out 1; `write_gnt` in 1.
- `read_req` out 1; `read_gnt` in 1.
- `din` out DATA_W, write data.
- `dout` in DATA_W, read data.
- `read_valid` in 1, read data strobe.
- `running`, `done`, `fail`, `timeout` out 1, status flags.
- `err_count`, `pass_count` out ERR_W, saturating counters.
- `fail_addr` out ADDR_W; `fail_exp`, `fail_got` out DATA_W, first-failure capture.

## Operation
- States: IDLE, WAIT_INIT, WR_REQ, WR_STEP, RD_REQ, RD_WAIT, RD_CHK, DONE, FAIL.
- IDLE/DONE/FAIL + `start`:
  - clear counters, capture registers and flags;
  - latch `mode`/`loop`/`stop_on_err`;
  - `clken`←1; go to WAIT_INIT.
- `start` is ignored in every other state.
- WAIT_INIT: wait for a falling edge of `busy` (registered copy of `busy` high, live `busy` low). Then reload the LFSR, set addr←0, go to WR_REQ.
- WR_REQ: `write_req`=1 with `w_addr`/`din` stable. On a `write_gnt` rising edge, drop `write_req` and go to WR_STEP.
- WR_STEP (1 cycle): advance addr/LFSR. At the last address instead: addr←0, reload LFSR, go to RD_REQ.
- RD_REQ: `read_req`=1. On a `read_gnt` rising edge, drop `read_req`, start the timeout counter, go to RD_WAIT.
- RD_WAIT: on a `read_valid` rising edge, register `dout` and go to RD_CHK. If the timer reaches `RD_TIMEOUT`, set `timeout`, treat the got value as 0, and go to RD_CHK.
- RD_CHK (1 cycle): compare against expected.
  - On mismatch or timeout: `err_count`+1, saturating at all ones. If `err_count` was 0, capture `fail_addr`/`fail_exp`/`fail_got`. If `stop_on_err`, go to FAIL.
  - Otherwise advance addr/LFSR and go to RD_REQ.
  - After the last address: `pass_count`+1 (saturating). If `loop`, reload the LFSR, addr←0, go to WR_REQ; else go to DONE.
- Pattern for address `a`, with `inv` = `pass_count[0]` (all ones XORed into data on odd passes):
  - address: `a` zero-extended or truncated to DATA_W;
  - LFSR: current LFSR value; step is `{l[DATA_W-2:0],0} ^ (l[DATA_W-1] ? LFSR_POLY : 0)`;
  - checkerboard: `a[0]` ? 0xAA… : 0x55…;
  - walking-one: `1 << (a mod DATA_W)`.
- `fail` is high in FAIL, and also in DONE when `err_count` ≠ 0.
- `running` is high in every state except IDLE, DONE and FAIL.
- `clken` stays 1 after the first start until reset.
- Reset mid-operation aborts immediately; all state returns to IDLE.
- Any request/grant glitches on the controller side are the controller's concern; the controller sees a request drop on its next edge.

## Timing
- Reset values: `clken`, `write_req`, `read_req`, `running`, `done`, `fail`, `timeout` = 0; all counters, addresses, `din` and capture registers = 0; state IDLE.
- `start` at cycle N → `running`=1 and `clken`=1 at N+1.
- Falling `busy` seen at cycle M → `write_req`=1 at M+1, with `w_addr`=0 and `din`=pattern(0).
- `write_gnt` rise at cycle G → `write_req`=0 at G+1, new address at G+2, `write_req`=1 at G+2. Minimum 3 cycles per write plus controller latency.
- `read_valid` rise at cycle V → compare at V+1; counters and capture registers update at V+2.
- Addresses and `din` are registered and change only in WR_STEP or RD_CHK.

## Structure
- Package `sdram_test_pkg`: state encoding, mode codes, checkerboard constant function, default `LFSR_POLY`.
- One sub-module, `sdram_test_pattern`:
  - inputs: mode, addr, inv, `lfsr_load`, `lfsr_step`;
  - output: data;
  - contains the LFSR register.
- The FSM, counters and capture registers live in the top-level module.

## Test plan
All cases use `ADDR_W`=4, `DATA_W`=8, `RD_TIMEOUT`=16 and a behavioural controller model: `busy` high for 50 cycles, grant 3 cycles after request, `read_valid` 4 cycles after grant.
- Mode 0, no loop → 16 writes with `din`=addr, then 16 reads; `done`=1, `err_count`=0, `pass_count`=1.
- Mode 1 → written `din` sequence starts at 0xFF (seed); read-back expected values match the write order; `done`=1, `err_count`=0.
- Model corrupts addr 5 (got 0x00, mode 2) → `err_count`=1, `fail_addr`=5, `fail_exp`=0xAA, `fail_got`=0x00. With `stop_on_err`=1 → FAIL entered right after the read of addr 5, `fail`=1.
- Mode 3 with `loop`=1 over 2 passes → pass 2 writes inverted data (addr 2 → 0xFB); `pass_count`=2; no errors.
- Model never raises `read_valid` for addr 0 → `timeout`=1 17 cycles after the grant; `fail_got`=0; `err_count`=1.
- `reset` asserted in the middle of RD_WAIT → all outputs return to their reset values asynchronously; a new `start` after the busy edge reruns cleanly. A `start` pulse while running is ignored.
